// File: rtl/pipeline_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Optional build macro HAZARD_FWD_EN (see hazard_detect) selects forwarding-aware detection.
package pipeline_pkg;

  localparam int REG_ADDR_W = 5;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    DMEM_WAIT = 2'd1,
    ERROR     = 2'd2
  } ctrlState_t;

  // A source operand depends on a writer only if the writer targets a real register.
  function automatic logic regMatch(input logic [REG_ADDR_W-1:0] destAddr,
                                    input logic [REG_ADDR_W-1:0] srcAddr);
    return (destAddr != REG_ZERO) && (destAddr == srcAddr);
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Pipeline-side handshake bundle: hazard/redirect/memory status in, stage enables and flushes out.
// The pipeline datapath is the master; the hazard controller is the slave.
interface pipeline_hazard_ctrl_if;
  import pipeline_pkg::*;

  logic [REG_ADDR_W-1:0] id_rs_addr;
  logic [REG_ADDR_W-1:0] id_rt_addr;
  logic                  id_uses_rt;
  logic                  ex_reg_write;
  logic                  ex_mem_read;
  logic [REG_ADDR_W-1:0] ex_dest_addr;
  logic                  mem_reg_write;
  logic [REG_ADDR_W-1:0] mem_dest_addr;
  logic                  ex_redirect;
  logic                  dmem_req;
  logic                  dmem_ready;
  logic                  pc_en;
  logic                  if_id_en;
  logic                  id_ex_en;
  logic                  ex_mem_en;
  logic                  mem_wb_en;
  logic                  if_id_flush;
  logic                  id_ex_flush;

  modport master (
    output id_rs_addr, id_rt_addr, id_uses_rt, ex_reg_write, ex_mem_read, ex_dest_addr,
           mem_reg_write, mem_dest_addr, ex_redirect, dmem_req, dmem_ready,
    input  pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush
  );

  modport slave (
    input  id_rs_addr, id_rt_addr, id_uses_rt, ex_reg_write, ex_mem_read, ex_dest_addr,
           mem_reg_write, mem_dest_addr, ex_redirect, dmem_req, dmem_ready,
    output pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush
  );

endinterface

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// Combinational RAW hazard detection for the instruction in ID.
// HAZARD_FWD_EN defined: full forwarding exists, only load-use stalls (one bubble).
// Undefined: any pending writer in EX or MEM stalls; WB is covered by write-before-read.
module hazard_detect
  import pipeline_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] id_rs_addr,
  input  logic [REG_ADDR_W-1:0] id_rt_addr,
  input  logic                  id_uses_rt,
  input  logic                  ex_reg_write,
  input  logic                  ex_mem_read,
  input  logic [REG_ADDR_W-1:0] ex_dest_addr,
  input  logic                  mem_reg_write,
  input  logic [REG_ADDR_W-1:0] mem_dest_addr,
  output logic                  hazard
);

  logic exMatch;
  logic memMatch;

  assign exMatch  = regMatch(ex_dest_addr, id_rs_addr) ||
                    (id_uses_rt && regMatch(ex_dest_addr, id_rt_addr));
  assign memMatch = regMatch(mem_dest_addr, id_rs_addr) ||
                    (id_uses_rt && regMatch(mem_dest_addr, id_rt_addr));

`ifdef HAZARD_FWD_EN
  // Loaded data is not available for forwarding until after MEM.
  assign hazard = ex_mem_read && ex_reg_write && exMatch;
`else
  // Without forwarding, wait until the producer has left MEM.
  assign hazard = (ex_reg_write && exMatch) || (mem_reg_write && memMatch);
`endif

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush scheduler for the 5-stage pipeline: stage enables, flushes, memory-wait FSM,
// saturating stall/flush counters and a sticky data-memory timeout error.
// Optional build macro HAZARD_FWD_EN selects forwarding-aware hazard detection.
module pipeline_hazard_ctrl
  import pipeline_pkg::*;
#(
  parameter int CNT_W        = 16,
  parameter int DMEM_TIMEOUT = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  pipeline_hazard_ctrl_if.slave  bus,
  output logic [CNT_W-1:0]       stall_cycles,
  output logic [CNT_W-1:0]       flush_count,
  output logic                   dmem_err,
  output logic [1:0]             state_o
);

  localparam int WAIT_W = (DMEM_TIMEOUT > 1) ? $clog2(DMEM_TIMEOUT + 1) : 1;
  localparam logic [WAIT_W-1:0] TIMEOUT_V = WAIT_W'(DMEM_TIMEOUT);

  ctrlState_t        stateQ, stateD;
  logic [WAIT_W-1:0] waitCntQ, waitCntD;
  logic              hazard;
  logic [4:0]        runEn, en;
  logic              runIfFlush, runIdFlush, runRedirect;
  logic              ifFlush, idFlush, redirectAccept;

  function automatic logic [CNT_W-1:0] satIncCnt(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  function automatic logic [WAIT_W-1:0] satIncWait(input logic [WAIT_W-1:0] v);
    return (&v) ? v : v + WAIT_W'(1);
  endfunction

  hazard_detect uHazard (
    .id_rs_addr    (bus.id_rs_addr),
    .id_rt_addr    (bus.id_rt_addr),
    .id_uses_rt    (bus.id_uses_rt),
    .ex_reg_write  (bus.ex_reg_write),
    .ex_mem_read   (bus.ex_mem_read),
    .ex_dest_addr  (bus.ex_dest_addr),
    .mem_reg_write (bus.mem_reg_write),
    .mem_dest_addr (bus.mem_dest_addr),
    .hazard        (hazard)
  );

  // Normal-flow decision (no memory wait): redirect wins, since it squashes the stalled ID op.
  always_comb begin
    runEn       = 5'b11111;
    runIfFlush  = 1'b0;
    runIdFlush  = 1'b0;
    runRedirect = 1'b0;
    if (bus.ex_redirect) begin
      runIfFlush  = 1'b1;
      runIdFlush  = 1'b1;
      runRedirect = 1'b1;
    end else if (hazard) begin
      runEn      = 5'b00111;
      runIdFlush = 1'b1;
    end
  end

  // FSM next state and Mealy outputs; enables ordered {pc, if_id, id_ex, ex_mem, mem_wb}.
  always_comb begin
    stateD         = stateQ;
    waitCntD       = waitCntQ;
    en             = 5'b11111;
    ifFlush        = 1'b0;
    idFlush        = 1'b0;
    redirectAccept = 1'b0;
    unique case (stateQ)
      RUN: begin
        if (bus.dmem_req && !bus.dmem_ready) begin
          en       = 5'b00000;
          stateD   = DMEM_WAIT;
          waitCntD = WAIT_W'(1);
        end else begin
          en             = runEn;
          ifFlush        = runIfFlush;
          idFlush        = runIdFlush;
          redirectAccept = runRedirect;
        end
      end
      DMEM_WAIT: begin
        if (!bus.dmem_ready) begin
          // Whole pipe frozen, so a pending redirect stays in EX and is seen again.
          en       = 5'b00000;
          waitCntD = satIncWait(waitCntQ);
          if ((DMEM_TIMEOUT != 0) && (waitCntQ == TIMEOUT_V)) stateD = ERROR;
        end else begin
          en             = runEn;
          ifFlush        = runIfFlush;
          idFlush        = runIdFlush;
          redirectAccept = runRedirect;
          stateD         = RUN;
          waitCntD       = '0;
        end
      end
      ERROR: begin
        en = 5'b00000;
      end
      default: begin
        stateD = RUN;
      end
    endcase
    if (!rst_n) begin
      en             = 5'b00000;
      ifFlush        = 1'b1;
      idFlush        = 1'b1;
      redirectAccept = 1'b0;
    end
  end

  assign bus.pc_en       = en[4];
  assign bus.if_id_en    = en[3];
  assign bus.id_ex_en    = en[2];
  assign bus.ex_mem_en   = en[1];
  assign bus.mem_wb_en   = en[0];
  assign bus.if_id_flush = ifFlush;
  assign bus.id_ex_flush = idFlush;
  assign dmem_err        = (stateQ == ERROR);
  assign state_o         = stateQ;

  // State, wait counter and saturating performance counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stateQ       <= RUN;
      waitCntQ     <= '0;
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      stateQ   <= stateD;
      waitCntQ <= waitCntD;
      if (!en[4])         stall_cycles <= satIncCnt(stall_cycles);
      if (redirectAccept) flush_count  <= satIncCnt(flush_count);
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl with a queued scoreboard of expected outputs.
// Expectations adapt to the HAZARD_FWD_EN build macro.
module tb_pipeline_hazard_ctrl;

  localparam int CNT_W = 16;
  localparam int TMO   = 4;

`ifdef HAZARD_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  localparam logic [4:0] EN_ALL  = 5'b11111;
  localparam logic [4:0] EN_NONE = 5'b00000;
  localparam logic [4:0] EN_HAZ  = 5'b00111;
  localparam logic [1:0] FL_NONE = 2'b00;
  localparam logic [1:0] FL_ID   = 2'b01;
  localparam logic [1:0] FL_BOTH = 2'b11;
  localparam logic [1:0] S_RUN   = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_ERR   = 2'd2;

  typedef struct packed {
    logic [4:0] en;
    logic [1:0] fl;
    logic [1:0] st;
    logic       redir;
  } exp_t;

  logic             clk;
  logic             rst_n;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_count;
  logic             dmem_err;
  logic [1:0]       state_o;

  int errors = 0;
  int checks = 0;
  int expStall = 0;
  int expFlush = 0;
  exp_t sb[$];

  pipeline_hazard_ctrl_if bus ();

  pipeline_hazard_ctrl #(.CNT_W(CNT_W), .DMEM_TIMEOUT(TMO)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .stall_cycles (stall_cycles),
    .flush_count  (flush_count),
    .dmem_err     (dmem_err),
    .state_o      (state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [4:0] obsEn();
    return {bus.pc_en, bus.if_id_en, bus.id_ex_en, bus.ex_mem_en, bus.mem_wb_en};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic setIn(input logic [4:0] rs, input logic [4:0] rt, input logic usesRt,
                       input logic exRw, input logic exMr, input logic [4:0] exDst,
                       input logic memRw, input logic [4:0] memDst, input logic redir,
                       input logic req, input logic rdy);
    bus.id_rs_addr    = rs;
    bus.id_rt_addr    = rt;
    bus.id_uses_rt    = usesRt;
    bus.ex_reg_write  = exRw;
    bus.ex_mem_read   = exMr;
    bus.ex_dest_addr  = exDst;
    bus.mem_reg_write = memRw;
    bus.mem_dest_addr = memDst;
    bus.ex_redirect   = redir;
    bus.dmem_req      = req;
    bus.dmem_ready    = rdy;
  endtask

  // Push the expected cycle result, compare at the falling edge, then advance the model.
  task automatic step(input string tag, input logic [4:0] en, input logic [1:0] fl,
                      input logic [1:0] st, input logic redir);
    exp_t e;
    sb.push_back('{en: en, fl: fl, st: st, redir: redir});
    @(negedge clk);
    e = sb.pop_front();
    check({tag, ".en"},    32'(obsEn()), 32'(e.en));
    check({tag, ".flush"}, 32'({bus.if_id_flush, bus.id_ex_flush}), 32'(e.fl));
    check({tag, ".state"}, 32'(state_o), 32'(e.st));
    check({tag, ".err"},   32'(dmem_err), 32'(e.st == S_ERR));
    check({tag, ".stall"}, 32'(stall_cycles), 32'(expStall));
    check({tag, ".flcnt"}, 32'(flush_count), 32'(expFlush));
    if (!rst_n) begin
      expStall = 0;
      expFlush = 0;
    end else begin
      if (!e.en[4]) expStall++;
      if (e.redir)  expFlush++;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit found;
    rst_n = 1'b0;
    setIn(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    step("reset", EN_NONE, FL_BOTH, S_RUN, 1'b0);
    rst_n = 1'b1;
    step("idle", EN_ALL, FL_NONE, S_RUN, 1'b0);

    // lw $t0 in EX, ID reads $t0; then the load moves to MEM.
    setIn(5'd8, 5'd3, 1'b0, 1'b1, 1'b1, 5'd8, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    step("loaduse_ex", EN_HAZ, FL_ID, S_RUN, 1'b0);
    setIn(5'd8, 5'd3, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0);
    step("loaduse_mem", FWD ? EN_ALL : EN_HAZ, FWD ? FL_NONE : FL_ID, S_RUN, 1'b0);
    setIn(5'd8, 5'd3, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    step("loaduse_done", EN_ALL, FL_NONE, S_RUN, 1'b0);

    // add writes $t1 in EX, ID reads $t1 through rt.
    setIn(5'd2, 5'd9, 1'b1, 1'b1, 1'b0, 5'd9, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    step("raw_ex", FWD ? EN_ALL : EN_HAZ, FWD ? FL_NONE : FL_ID, S_RUN, 1'b0);
    setIn(5'd2, 5'd9, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0);
    step("raw_mem", FWD ? EN_ALL : EN_HAZ, FWD ? FL_NONE : FL_ID, S_RUN, 1'b0);
    setIn(5'd2, 5'd9, 1'b0, 1'b1, 1'b0, 5'd9, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    step("rt_unused", EN_ALL, FL_NONE, S_RUN, 1'b0);

    // Register zero never creates a dependency.
    setIn(5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
    step("zero_reg", EN_ALL, FL_NONE, S_RUN, 1'b0);

    // Redirect together with a load-use: flush both, no stall.
    setIn(5'd8, 5'd0, 1'b0, 1'b1, 1'b1, 5'd8, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
    step("redirect", EN_ALL, FL_BOTH, S_RUN, 1'b1);

    // Memory wait of three cycles with a redirect held in EX, accepted on completion.
    setIn(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0);
    step("dwait1", EN_NONE, FL_NONE, S_RUN, 1'b0);
    step("dwait2", EN_NONE, FL_NONE, S_WAIT, 1'b0);
    step("dwait3", EN_NONE, FL_NONE, S_WAIT, 1'b0);
    bus.dmem_ready = 1'b1;
    step("dready", EN_ALL, FL_BOTH, S_WAIT, 1'b1);
    setIn(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    step("after_wait", EN_ALL, FL_NONE, S_RUN, 1'b0);

    // Memory never answers: must reach ERROR within a bounded number of cycles.
    setIn(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    step("tmo_start", EN_NONE, FL_NONE, S_RUN, 1'b0);
    found = 1'b0;
    for (int i = 0; i < 16 && !found; i++) begin
      @(negedge clk);
      check("tmo_en", 32'(obsEn()), 32'(EN_NONE));
      expStall++;
      if (state_o == S_ERR) found = 1'b1;
      else begin
        @(posedge clk);
        #1;
      end
    end
    checks++;
    assert (found) else begin
      errors++;
      $error("FAIL tmo_reach observed=%0d expected=%0d", state_o, S_ERR);
    end
    @(posedge clk);
    #1;
    bus.dmem_ready = 1'b1;
    bus.ex_redirect = 1'b1;
    step("err_hold1", EN_NONE, FL_NONE, S_ERR, 1'b0);
    step("err_hold2", EN_NONE, FL_NONE, S_ERR, 1'b0);
    rst_n = 1'b0;
    step("err_reset", EN_NONE, FL_BOTH, S_ERR, 1'b0);
    rst_n = 1'b1;
    setIn(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    step("post_reset", EN_ALL, FL_NONE, S_RUN, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
